// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the RISC-V core.
// Keeps the fetch PC and issues one instruction-memory read per cycle.
// Returned instructions land in a 2-entry FIFO, so decode can stall
// without losing data.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   redirect_i            flush and restart fetch at redirect_pc_i
//   redirect_pc_i         new PC from the target mux; bits [1:0] are ignored
//   imem_req_o            read request this cycle (always accepted)
//   imem_addr_o           read address (current fetch PC)
//   imem_rdata_i          instruction returned one cycle after a request
//   if_valid_o            FIFO head holds a valid instruction
//   if_ready_i            decode accepts the head this cycle
//   if_pc_o, if_instr_o   head PC and instruction (0 when empty)
module fetch_stage #(
  parameter int             DW       = 32,
  parameter logic [DW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_i,
  input  logic [DW-1:0] redirect_pc_i,
  output logic          imem_req_o,
  output logic [DW-1:0] imem_addr_o,
  input  logic [DW-1:0] imem_rdata_i,
  output logic          if_valid_o,
  input  logic          if_ready_i,
  output logic [DW-1:0] if_pc_o,
  output logic [DW-1:0] if_instr_o
);

  logic [DW-1:0] fetch_pc;
  logic          inflight;
  logic [DW-1:0] inflight_pc;
  logic [DW-1:0] fifo_pc    [2];
  logic [DW-1:0] fifo_instr [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;

  logic          pop;
  logic          push;
  logic          req;
  logic [2:0]    occ;

  assign pop  = (count != 2'd0) & if_ready_i;
  // A response is present whenever a request went out last cycle;
  // a redirect in the same cycle discards it.
  assign push = inflight & ~redirect_i;

  // Occupancy after this cycle, counting the in-flight read as a reserved
  // slot. Never negative: pop implies count >= 1.
  assign occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign req = rst_n & ~redirect_i & (occ < 3'd2);

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc;
  assign if_valid_o  = (count != 2'd0);
  // Zero outputs when empty, so they read 0 while held in reset.
  assign if_pc_o     = if_valid_o ? fifo_pc[rd_ptr]    : '0;
  assign if_instr_o  = if_valid_o ? fifo_instr[rd_ptr] : '0;

  // ---- request stage: PC and in-flight tracking ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[DW-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= req;
      if (req) fetch_pc <= fetch_pc + DW'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (req) inflight_pc <= fetch_pc;
  end

  // ---- response stage: FIFO control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push) wr_ptr <= ~wr_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= inflight_pc;
      fifo_instr[wr_ptr] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] K    = 32'hA5A5_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT
  logic        rst_n, redirect, ready;
  logic [31:0] redirect_pc, rdata;
  logic        req, valid;
  logic [31:0] addr, pc, instr;

  // second DUT with a wrapping reset PC
  logic        rst_n2, redirect2, ready2;
  logic [31:0] redirect_pc2, rdata2;
  logic        req2, valid2;
  logic [31:0] addr2, pc2, instr2;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata),
    .if_valid_o(valid), .if_ready_i(ready), .if_pc_o(pc), .if_instr_o(instr)
  );

  fetch_stage #(.DW(32), .RESET_PC(RPC2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_rdata_i(rdata2),
    .if_valid_o(valid2), .if_ready_i(ready2), .if_pc_o(pc2), .if_instr_o(instr2)
  );

  // Instruction memory: data one cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    rdata  <= req  ? (addr  ^ K) : $urandom;
    rdata2 <= req2 ? (addr2 ^ K) : $urandom;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;
  int delivered = 0;
  int got2      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the delivered stream is the sequence of word
  // addresses starting at the most recent reset/redirect target.
  logic [31:0] exp_q[$];
  logic [31:0] last_pc;

  task automatic start_stream(input logic [31:0] start);
    exp_q.delete();
    exp_q.push_back(start);
    last_pc = start;
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      last_pc = last_pc + 32'd4;
      exp_q.push_back(last_pc);
    end
  endtask

  // Monitor: compare every handshake against the expected stream, then
  // apply this cycle's reset/redirect to the model.
  always @(negedge clk) begin
    logic [31:0] e;
    if (valid && ready) begin
      if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("sb_pc", pc, e);
        check("sb_instr", instr, e ^ K);
        delivered++;
      end
    end
    check("no_overflow", {31'd0, (dut.count <= 2'd2)}, 32'd1);
    if (!rst_n)        start_stream(32'h0);
    else if (redirect) start_stream(redirect_pc & ~32'd3);
    refill();
  end

  // Monitor for the wrapping-PC instance: first four deliveries.
  always @(negedge clk) begin
    logic [31:0] e2;
    if (rst_n2 && valid2 && ready2 && got2 < 4) begin
      e2 = RPC2 + 32'(got2 * 4);
      check("wrap_pc", pc2, e2);
      check("wrap_instr", instr2, e2 ^ K);
      got2++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] head;
    rst_n = 0; redirect = 0; ready = 1; redirect_pc = 0;
    rst_n2 = 0; redirect2 = 0; ready2 = 1; redirect_pc2 = 0;
    repeat (3) tick();

    // reset state
    @(negedge clk);
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst2_addr", addr2, RPC2);
    tick();
    rst_n = 1; rst_n2 = 1;

    // first fetches and latency
    @(negedge clk);
    check("c0_req", {31'd0, req}, 32'd1);
    check("c0_addr", addr, 32'h0);
    check("c0_valid", {31'd0, valid}, 32'd0);
    tick();
    @(negedge clk);
    check("c1_addr", addr, 32'h4);
    check("c1_valid", {31'd0, valid}, 32'd0);
    tick();
    @(negedge clk);
    check("c2_valid", {31'd0, valid}, 32'd1);
    check("c2_pc", pc, 32'h0);
    repeat (10) tick();

    // stall for 10 cycles
    ready = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) head = pc;
      else begin
        check("stall_req", {31'd0, req}, 32'd0);
        check("stall_valid", {31'd0, valid}, 32'd1);
        check("stall_head", pc, head);
      end
      tick();
    end
    ready = 1;
    @(negedge clk);
    check("resume_req", {31'd0, req}, 32'd1);
    repeat (5) tick();

    // fill the FIFO, then redirect to a misaligned target
    ready = 0;
    repeat (3) tick();
    redirect = 1; redirect_pc = 32'h0000_1002;
    @(negedge clk);
    check("redir_req", {31'd0, req}, 32'd0);
    tick();
    redirect = 0; ready = 1;
    @(negedge clk);
    check("r1_valid", {31'd0, valid}, 32'd0);
    check("r1_req", {31'd0, req}, 32'd1);
    check("r1_addr", addr, 32'h0000_1000);
    tick();
    @(negedge clk);
    check("r2_valid", {31'd0, valid}, 32'd0);
    check("r2_addr", addr, 32'h0000_1004);
    tick();
    @(negedge clk);
    check("r3_valid", {31'd0, valid}, 32'd1);
    check("r3_pc", pc, 32'h0000_1000);
    repeat (4) tick();

    // three consecutive redirects
    for (int k = 1; k <= 3; k++) begin
      redirect = 1; redirect_pc = 32'(k * 32'h100);
      @(negedge clk);
      check("multi_req", {31'd0, req}, 32'd0);
      tick();
    end
    redirect = 0;
    @(negedge clk);
    check("multi_next_req", {31'd0, req}, 32'd1);
    check("multi_next_addr", addr, 32'h300);
    check("multi_next_valid", {31'd0, valid}, 32'd0);
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    check("multi_first_pc", pc, 32'h300);
    repeat (3) tick();

    // random ready / redirects with a one-cycle reset pulse
    for (int c = 0; c < 600; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom_range(0, 32'hFFFF);
      if (c == 300) begin
        redirect = 0;
        rst_n = 0;
        #1;
        check("arst_req", {31'd0, req}, 32'd0);
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_addr", addr, 32'h0);
        check("arst_pc", pc, 32'h0);
        check("arst_instr", instr, 32'h0);
        tick();
        rst_n = 1;
        @(negedge clk);
        check("arst_restart_addr", addr, 32'h0);
        check("arst_restart_req", {31'd0, req}, 32'd1);
      end
      tick();
    end
    redirect = 0; ready = 1;
    repeat (5) tick();

    check("delivered_enough", {31'd0, (delivered > 200)}, 32'd1);
    check("wrap_count", 32'(got2), 32'd4);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
